// File: rtl/rate_limit_pkg.sv
// Shared types for the stream rate limiter.
// Packet-boundary FSM states and statistics counter width.
package rate_limit_pkg;

    localparam int STAT_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

endpackage

// File: rtl/token_bucket.sv
// Token bucket for the stream rate limiter: period counter,
// refill, per-beat consume, debt floor and ceiling clamp.
module token_bucket
    import rate_limit_pkg::*;
#(
    parameter int TOKEN_WIDTH  = 16,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [TOKEN_WIDTH-2:0]  cfg_refill,
    input  logic [PERIOD_WIDTH-1:0] cfg_period,
    input  logic [TOKEN_WIDTH-2:0]  cfg_bucket_max,
    input  logic                    consume,
    output logic                    tokens_positive
);

    localparam int SW = TOKEN_WIDTH + 2;

    logic signed [TOKEN_WIDTH-1:0] tokens;
    logic        [PERIOD_WIDTH-1:0] period_cnt;
    logic                           refill;

    logic signed [SW-1:0] tok_ext;
    logic signed [SW-1:0] add_ext;
    logic signed [SW-1:0] dec_ext;
    logic signed [SW-1:0] max_ext;
    logic signed [SW-1:0] min_ext;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] sum_sat;

    // Counter beyond cfg_period (after a cfg change) wraps at once.
    assign refill = (period_cnt >= cfg_period);

    always_comb begin
        tok_ext = {{2{tokens[TOKEN_WIDTH-1]}}, tokens};
        add_ext = refill ? {3'b000, cfg_refill} : '0;
        dec_ext = {{(SW-1){1'b0}}, consume};
        max_ext = {3'b000, cfg_bucket_max};
        min_ext = {3'b111, {(TOKEN_WIDTH-1){1'b0}}};
        sum     = tok_ext + add_ext - dec_ext;
        sum_sat = sum;
        // Ceiling applies every cycle so a lowered max clamps promptly.
        if (sum > max_ext) begin
            sum_sat = max_ext;
        end else if (sum < min_ext) begin
            sum_sat = min_ext;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            period_cnt <= '0;
            tokens     <= '0;
        end else begin
            period_cnt <= refill ? '0
                                 : period_cnt + PERIOD_WIDTH'(1);
            tokens     <= sum_sat[TOKEN_WIDTH-1:0];
        end
    end

    assign tokens_positive = (tokens != '0) && !tokens[TOKEN_WIDTH-1];

endmodule

// File: rtl/stream_rate_limiter.sv
// Zero-latency packet-aware stream rate limiter.
// Define RATE_LIMIT_STATS_EN to build the statistics counters.
module stream_rate_limiter
    import rate_limit_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int TOKEN_WIDTH  = 16,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_last,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    cfg_enable,
    input  logic [TOKEN_WIDTH-2:0]  cfg_refill,
    input  logic [PERIOD_WIDTH-1:0] cfg_period,
    input  logic [TOKEN_WIDTH-2:0]  cfg_bucket_max,
    output logic [STAT_WIDTH-1:0]   stat_stall_cycles,
    output logic [STAT_WIDTH-1:0]   stat_pkts
);

    state_t state;
    logic   tokens_positive;
    logic   allow;
    logic   accept;

    // Mid-packet beats are never gated so packets stay contiguous.
    assign allow = resetn &
                   ((state == PKT) | ~cfg_enable | tokens_positive);

    assign out_data  = in_data;
    assign out_last  = in_last;
    assign out_valid = in_valid & allow;
    assign in_ready  = out_ready & allow;
    assign accept    = in_valid & in_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else if (accept) begin
            state <= in_last ? IDLE : PKT;
        end
    end

    token_bucket #(
        .TOKEN_WIDTH  (TOKEN_WIDTH),
        .PERIOD_WIDTH (PERIOD_WIDTH)
    ) u_bucket (
        .clk             (clk),
        .resetn          (resetn),
        .cfg_refill      (cfg_refill),
        .cfg_period      (cfg_period),
        .cfg_bucket_max  (cfg_bucket_max),
        .consume         (accept & cfg_enable),
        .tokens_positive (tokens_positive)
    );

`ifdef RATE_LIMIT_STATS_EN
    logic [STAT_WIDTH-1:0] stall_cnt;
    logic [STAT_WIDTH-1:0] pkt_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
            pkt_cnt   <= '0;
        end else begin
            if ((state == IDLE) && in_valid && !allow &&
                (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + STAT_WIDTH'(1);
            end
            if (accept && in_last && (pkt_cnt != '1)) begin
                pkt_cnt <= pkt_cnt + STAT_WIDTH'(1);
            end
        end
    end

    assign stat_stall_cycles = stall_cnt;
    assign stat_pkts         = pkt_cnt;
`else
    assign stat_stall_cycles = '0;
    assign stat_pkts         = '0;
`endif

endmodule

// File: tb/tb_stream_rate_limiter.sv
// Directed bench for stream_rate_limiter.
// Stat expectations follow RATE_LIMIT_STATS_EN.
module tb_stream_rate_limiter;
    import rate_limit_pkg::*;

    localparam int DW = 64;
    localparam int TW = 16;
    localparam int PW = 16;

`ifdef RATE_LIMIT_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic          clk;
    logic          resetn;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          cfg_enable;
    logic [TW-2:0] cfg_refill;
    logic [PW-1:0] cfg_period;
    logic [TW-2:0] cfg_bucket_max;
    logic [31:0]   stat_stall_cycles;
    logic [31:0]   stat_pkts;

    int n_pass;
    int n_total;

    stream_rate_limiter #(
        .DATA_WIDTH   (DW),
        .TOKEN_WIDTH  (TW),
        .PERIOD_WIDTH (PW)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .in_data           (in_data),
        .in_last           (in_last),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .out_data          (out_data),
        .out_last          (out_last),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .cfg_enable        (cfg_enable),
        .cfg_refill        (cfg_refill),
        .cfg_period        (cfg_period),
        .cfg_bucket_max    (cfg_bucket_max),
        .stat_stall_cycles (stat_stall_cycles),
        .stat_pkts         (stat_pkts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Leaves the caller in the slot of cycle 0 after release.
    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        int acc;
        int first;
        int second;
        int c;

        n_pass         = 0;
        n_total        = 0;
        resetn         = 1'b0;
        in_data        = 64'hAA;
        in_last        = 1'b0;
        in_valid       = 1'b1;
        out_ready      = 1'b1;
        cfg_enable     = 1'b0;
        cfg_refill     = 15'd1;
        cfg_period     = 16'd9;
        cfg_bucket_max = 15'd8;

        // Reset state
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_tokens", 64'(dut.u_bucket.tokens), 64'd0);
        chk("rst_stall", 64'(stat_stall_cycles), 64'd0);
        chk("rst_pkts", 64'(stat_pkts), 64'd0);

        // Transparent mode, back-to-back 4-beat packets
        resetn = 1'b1;
        acc = 0;
        for (int b = 0; b < 12; b++) begin
            in_data  = 64'(b) + 64'd100;
            in_last  = (b % 4 == 3);
            in_valid = 1'b1;
            #1;
            if (in_ready && out_valid) acc++;
            if (b == 6) chk("xp_data", out_data, 64'd106);
            if (b == 7) chk("xp_last", 64'(out_last), 64'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("xp_beats", 64'(acc), 64'd12);
        chk("xp_stall", 64'(stat_stall_cycles), 64'd0);
        chk("xp_pkts", 64'(stat_pkts), 64'(3 * STATS));

        // Steady 1 beat per 10 cycles from reset
        cfg_enable = 1'b1;
        in_valid   = 1'b1;
        in_last    = 1'b1;
        do_reset();
        first  = -1;
        second = -1;
        acc    = 0;
        for (int k = 0; k <= 40; k++) begin
            #1;
            if (in_ready) begin
                acc++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("lim_first", 64'(first), 64'd10);
        chk("lim_second", 64'(second), 64'd20);
        chk("lim_count", 64'(acc), 64'd4);
        chk("lim_stall", 64'(stat_stall_cycles), 64'(37 * STATS));
        chk("lim_pkts", 64'(stat_pkts), 64'(4 * STATS));

        // One token lets a whole 5-beat packet through into debt
        do_reset();
        repeat (10) @(negedge clk);
        acc = 0;
        for (int b = 0; b < 5; b++) begin
            in_valid = 1'b1;
            in_last  = (b == 4);
            #1;
            if (in_ready) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("debt_beats", 64'(acc), 64'd5);
        chk("debt_tokens", 64'(dut.u_bucket.tokens), -64'sd4);
        in_valid = 1'b1;
        in_last  = 1'b1;
        first = -1;
        for (c = 15; c < 80; c++) begin
            #1;
            if (in_ready) begin
                first = c;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("debt_next_pkt", 64'(first), 64'd60);

        // Refill saturates at the bucket ceiling
        cfg_refill     = 15'd3;
        cfg_period     = 16'd0;
        cfg_bucket_max = 15'd8;
        do_reset();
        @(negedge clk);
        #1;
        chk("sat_tok1", 64'(dut.u_bucket.tokens), 64'd3);
        repeat (9) @(negedge clk);
        #1;
        chk("sat_tok10", 64'(dut.u_bucket.tokens), 64'd8);

        // Lowered ceiling clamps tokens
        cfg_refill     = 15'd0;
        cfg_bucket_max = 15'd2;
        @(negedge clk);
        #1;
        chk("clamp_tok", 64'(dut.u_bucket.tokens), 64'd2);

        // Refill and consume together leave tokens unchanged
        cfg_refill     = 15'd1;
        cfg_bucket_max = 15'd8;
        in_valid       = 1'b1;
        in_last        = 1'b1;
        #1;
        chk("rc_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("rc_tokens", 64'(dut.u_bucket.tokens), 64'd2);

        // Reset mid-packet
        cfg_refill = 15'd0;
        in_valid   = 1'b1;
        in_last    = 1'b0;
        #1;
        chk("mid_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        #1;
        chk("mid_state", 64'(dut.state), 64'(PKT));
        resetn = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_state", 64'(dut.state), 64'(IDLE));
        chk("mid_rst_tokens", 64'(dut.u_bucket.tokens), 64'd0);
        cfg_refill = 15'd1;
        cfg_period = 16'd9;
        in_last    = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("mid_gated", 64'(in_ready), 64'd0);
        first = -1;
        for (int k = 0; k < 30; k++) begin
            if (k > 0) #1;
            if (in_ready) begin
                first = k;
                break;
            end
            @(negedge clk);
        end
        chk("mid_first", 64'(first), 64'd10);
        @(negedge clk);
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
